// File: rtl/output_drain_quant_pkg.sv
// Shared constants and FSM encoding for the output drain / requantization block.
// The optional ReLU clamp is selected by the OUTPUT_RELU_EN macro (see requant_lane).
package output_drain_quant_pkg;

    localparam int DEF_ARRAYWIDTH          = 8;
    localparam int DEF_OUTPUT_BUF_DATASIZE = 32;
    localparam int DEF_OUTPUT_QUANT_WIDTH  = 8;
    localparam int SHAMT_W                 = 5;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_RUN   = 2'd1,
        DRAIN_FLUSH = 2'd2
    } drain_state_e;

endpackage

// File: rtl/output_drain_quant_requant_lane.sv
// One column of requantization: arithmetic shift with round-half-up, signed saturation,
// and an optional clamp of negatives to zero when OUTPUT_RELU_EN is defined.
module requant_lane
    import output_drain_quant_pkg::*;
#(
    parameter int IN_W  = DEF_OUTPUT_BUF_DATASIZE,
    parameter int OUT_W = DEF_OUTPUT_QUANT_WIDTH
) (
    input  logic signed [IN_W-1:0]    x_i,
    input  logic        [SHAMT_W-1:0] shamt_i,
    output logic        [OUT_W-1:0]   y_o
);

    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

    logic signed [IN_W:0] xe;
    logic signed [IN_W:0] bias;
    logic signed [IN_W:0] r;
    logic [OUT_W-1:0]     sat;

    // One extra bit keeps x + half-LSB from overflowing before the shift.
    always_comb begin
        xe   = {x_i[IN_W-1], x_i};
        bias = '0;
        if (shamt_i != '0) begin
            bias = (IN_W+1)'(1) << (shamt_i - SHAMT_W'(1));
        end
        r = (xe + bias) >>> shamt_i;
        if (r > MAX_V) begin
            sat = MAX_V[OUT_W-1:0];
        end else if (r < MIN_V) begin
            sat = MIN_V[OUT_W-1:0];
        end else begin
            sat = r[OUT_W-1:0];
        end
`ifdef OUTPUT_RELU_EN
        if (sat[OUT_W-1]) begin
            sat = '0;
        end
`endif
        y_o = sat;
    end

endmodule

// File: rtl/output_drain_quant.sv
// Drains a finished tile from the output buffer row by row, requantizes each column and
// streams packed rows to the result writer. ReLU option: OUTPUT_RELU_EN.
module output_drain_quant
    import output_drain_quant_pkg::*;
#(
    parameter int ARRAYWIDTH = DEF_ARRAYWIDTH,
    parameter int IN_W       = DEF_OUTPUT_BUF_DATASIZE,
    parameter int OUT_W      = DEF_OUTPUT_QUANT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SHAMT_W-1:0]          shamt,
    output logic                        busy,
    output logic                        done,
    output logic                        buf_out_en,
    output logic                        buf_load_clear,
    input  logic [ARRAYWIDTH*IN_W-1:0]  buf_res,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [ARRAYWIDTH*OUT_W-1:0] wr_data,
    output logic                        wr_last
);

    localparam int                CNT_W    = $clog2(ARRAYWIDTH + 1);
    localparam logic [CNT_W-1:0]  ROWS     = CNT_W'(ARRAYWIDTH);
    localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(ARRAYWIDTH - 1);

    drain_state_e                state_q, state_d;
    logic [CNT_W-1:0]            issued_q, issued_d;
    logic [SHAMT_W-1:0]          shamt_q, shamt_d;
    logic                        done_q, done_d;
    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_last_q, s1_last_d;
    logic [ARRAYWIDTH*IN_W-1:0]  s1_data_q, s1_data_d;
    logic                        s2_valid_q, s2_valid_d;
    logic                        s2_last_q, s2_last_d;
    logic [ARRAYWIDTH*OUT_W-1:0] s2_data_q, s2_data_d;
    logic [ARRAYWIDTH*OUT_W-1:0] quant_row;

    logic s2_free;
    logic s1_adv;
    logic pop;
    logic accept_last;

    assign s2_free     = !s2_valid_q || wr_ready;
    assign s1_adv      = s1_valid_q && s2_free;
    assign pop         = (state_q == DRAIN_RUN) && (issued_q < ROWS) && (!s1_valid_q || s1_adv);
    assign accept_last = s2_valid_q && wr_ready && s2_last_q;

    for (genvar i = 0; i < ARRAYWIDTH; i++) begin : g_lane
        requant_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .x_i     (s1_data_q[i*IN_W +: IN_W]),
            .shamt_i (shamt_q),
            .y_o     (quant_row[i*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        shamt_d    = shamt_q;
        done_d     = 1'b0;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_data_d  = s2_data_q;

        // A popped row always lands in s1; s1 is only vacated when s2 can take it.
        if (pop) begin
            s1_valid_d = 1'b1;
            s1_data_d  = buf_res;
            s1_last_d  = (issued_q == LAST_ROW);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = quant_row;
            s2_last_d  = s1_last_q;
        end else if (wr_ready) begin
            s2_valid_d = 1'b0;
        end

        // The done cycle is still treated as busy for start acceptance.
        case (state_q)
            DRAIN_IDLE: begin
                if (start && !done_q) begin
                    state_d  = DRAIN_RUN;
                    issued_d = '0;
                    shamt_d  = shamt;
                end
            end
            DRAIN_RUN: begin
                if (pop) begin
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_q == LAST_ROW) begin
                        state_d = DRAIN_FLUSH;
                    end
                end
            end
            DRAIN_FLUSH: begin
                if (accept_last) begin
                    state_d = DRAIN_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = DRAIN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DRAIN_IDLE;
            issued_q   <= '0;
            shamt_q    <= '0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            shamt_q    <= shamt_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign busy           = (state_q != DRAIN_IDLE);
    assign done           = done_q;
    assign buf_load_clear = done_q;
    assign buf_out_en     = pop;
    assign wr_valid       = s2_valid_q;
    assign wr_data        = s2_data_q;
    assign wr_last        = s2_last_q;

endmodule

// File: tb/tb_output_drain_quant.sv
// Scoreboard bench for output_drain_quant: a buffer model feeds rows, a reference
// requantizer fills the expected queue, and a monitor checks every accepted beat.
module tb_output_drain_quant;

    localparam int AW    = 8;
    localparam int IN_W  = 32;
    localparam int OUT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [4:0]           shamt;
    logic                 busy;
    logic                 done;
    logic                 bufOutEn;
    logic                 bufLoadClear;
    logic [AW*IN_W-1:0]   bufRes;
    logic                 wrValid;
    logic                 wrReady;
    logic [AW*OUT_W-1:0]  wrData;
    logic                 wrLast;

    always #5 clk = ~clk;

    output_drain_quant #(
        .ARRAYWIDTH (AW),
        .IN_W       (IN_W),
        .OUT_W      (OUT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .shamt          (shamt),
        .busy           (busy),
        .done           (done),
        .buf_out_en     (bufOutEn),
        .buf_load_clear (bufLoadClear),
        .buf_res        (bufRes),
        .wr_valid       (wrValid),
        .wr_ready       (wrReady),
        .wr_data        (wrData),
        .wr_last        (wrLast)
    );

    typedef struct {
        logic [AW*OUT_W-1:0] data;
        logic                last;
    } beat_t;

    beat_t               expQ[$];
    logic [IN_W-1:0]     rowMem [AW][AW];
    int                  compared = 0;
    int                  mismatched = 0;
    int                  popCount;
    int                  popBase = 0;
    int                  cycle = 0;
    int                  beatIdx = 0;
    int                  firstAcc = 0;
    int                  lastAcc = 0;
    int                  readyPct = 100;
    logic                lastAccepted = 1'b0;
    logic                prevStall = 1'b0;
    logic [AW*OUT_W-1:0] prevData;
    logic                prevLast;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference requantizer written straight from the arithmetic rule.
    function automatic logic [OUT_W-1:0] refQuant(input longint x, input int s);
        longint r;
        if (s == 0) r = x;
        else r = (x + (longint'(1) << (s - 1))) >>> s;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`ifdef OUTPUT_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[OUT_W-1:0];
    endfunction

    // Output buffer model: the head row advances on every pop.
    always @(posedge clk or negedge rst) begin
        if (!rst) popCount <= 0;
        else if (bufOutEn) popCount <= popCount + 1;
    end

    always @(posedge clk) cycle <= cycle + 1;

    always_comb begin
        int idx;
        idx = popCount - popBase;
        if (idx < 0 || idx >= AW) idx = AW - 1;
        for (int c = 0; c < AW; c++) bufRes[c*IN_W +: IN_W] = rowMem[idx][c];
    end

    initial begin
        wrReady = 1'b0;
        forever begin
            @(posedge clk);
            #1 wrReady = ($urandom_range(0, 99) < readyPct);
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and done timing.
    always @(negedge clk) begin
        if (!rst) begin
            lastAccepted = 1'b0;
            prevStall    = 1'b0;
        end else begin
            if (lastAccepted || done || bufLoadClear) begin
                checkOutput("done_pulse", done, lastAccepted);
                checkOutput("buf_load_clear_pulse", bufLoadClear, lastAccepted);
            end
            lastAccepted = 1'b0;
            if (prevStall) begin
                checkOutput("stall_valid", wrValid, 1);
                checkOutput("stall_data", wrData, prevData);
                checkOutput("stall_last", wrLast, prevLast);
            end
            if (wrValid && wrReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput("beat_data", wrData, e.data);
                    checkOutput("beat_last", wrLast, e.last);
                    lastAccepted = e.last;
                end
                if (beatIdx == 0) firstAcc = cycle;
                lastAcc = cycle;
                beatIdx++;
            end
            prevStall = wrValid && !wrReady;
            prevData  = wrData;
            prevLast  = wrLast;
        end
    end

    task automatic fillRandom();
        for (int r = 0; r < AW; r++)
            for (int c = 0; c < AW; c++) begin
                logic [31:0] v;
                v = $urandom;
                rowMem[r][c] = $signed(v) >>> $urandom_range(0, 24);
            end
    endtask

    task automatic buildExpected(input int s);
        for (int r = 0; r < AW; r++) begin
            beat_t b;
            for (int c = 0; c < AW; c++) b.data[c*OUT_W +: OUT_W] = refQuant($signed(rowMem[r][c]), s);
            b.last = (r == AW - 1);
            expQ.push_back(b);
        end
    endtask

    task automatic applyStimulus(input int s, input int pct, input bit repulse);
        bit got;
        popBase  = popCount;
        beatIdx  = 0;
        readyPct = pct;
        buildExpected(s);
        @(posedge clk);
        #1 start = 1'b1;
        shamt = 5'(s);
        @(posedge clk);
        #1 start = 1'b0;
        shamt = 5'($urandom);
        checkOutput("busy_after_start", busy, 1);
        if (repulse) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            shamt = 5'(s) ^ 5'h15;
            @(posedge clk);
            #1 start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        checkOutput("done_seen", got, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("start_on_done_ignored", busy, 0);
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("pops_per_tile", popCount - popBase, AW);
        checkOutput("beats_per_tile", beatIdx, AW);
        if (pct == 100) checkOutput("no_bubble_span", lastAcc - firstAcc, AW - 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        shamt = '0;
        for (int r = 0; r < AW; r++)
            for (int c = 0; c < AW; c++) rowMem[r][c] = '0;
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_clear", bufLoadClear, 0);
        checkOutput("reset_pop", bufOutEn, 0);
        checkOutput("reset_valid", wrValid, 0);
        checkOutput("reset_last", wrLast, 0);
        checkOutput("reset_data", wrData, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Round-half-up on both signs: 296 -> 19, -296 -> -18.
        fillRandom();
        rowMem[0][0] = 32'sd296;
        rowMem[0][1] = -32'sd296;
        applyStimulus(4, 100, 1'b0);

        // Saturation at shift zero.
        fillRandom();
        rowMem[0][0] = 32'sd1000;
        rowMem[0][1] = -32'sd1000;
        applyStimulus(0, 100, 1'b0);

        for (int t = 0; t < 4; t++) begin
            fillRandom();
            applyStimulus($urandom_range(0, 31), 50, 1'b0);
        end

        fillRandom();
        applyStimulus(6, 50, 1'b1);

        // Abort mid-tile with rows parked in the pipeline.
        fillRandom();
        popBase  = popCount;
        readyPct = 0;
        @(posedge clk);
        #1 start = 1'b1;
        shamt = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        checkOutput("pre_reset_valid", wrValid, 1);
        #1 rst = 1'b0;
        #1;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_pop", bufOutEn, 0);
        checkOutput("midreset_valid", wrValid, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_clear", bufLoadClear, 0);
        checkOutput("midreset_data", wrData, 0);
        checkOutput("midreset_last", wrLast, 0);
        expQ.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        fillRandom();
        applyStimulus($urandom_range(0, 31), 100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
